// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoding definitions: format codes, opcode constants and
// small helpers used by the immediate encoder and its packer.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  typedef struct packed {
    logic [31:0] instr;
    logic        imm_err;
  } enc_t;

  // Codes 6 and 7 have no encoding.
  function automatic logic fmt_legal(input logic [2:0] fmt);
    return fmt <= 3'd5;
  endfunction

  // True when v[31:lsb] are all ones or all zeros (value fits as a signed field).
  function automatic logic upper_same(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << lsb;
    return ((v & mask) == mask) || ((v & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle of the immediate encoder: request fields with
// valid/ready, and the packed instruction with its own valid/ready.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        imm_err;

  modport master (
    output in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    input  in_ready, out_valid, instr, imm_err
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    output in_ready, out_valid, instr, imm_err
  );
endinterface

// File: rtl/imm_pack.sv
// Combinational RV32I field scatter plus immediate range check for one
// request. Illegal formats yield a zero word with the error flag set.
module imm_pack
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        imm_err_o
);

  always_comb begin
    instr_o   = 32'h0;
    imm_err_o = 1'b0;
    case (fmt_i)
      FmtR: begin
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      FmtI: begin
        instr_o   = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        imm_err_o = !upper_same(imm_i, 11);
      end
      FmtS: begin
        instr_o   = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        imm_err_o = !upper_same(imm_i, 11);
      end
      FmtB: begin
        instr_o   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], opcode_i};
        imm_err_o = imm_i[0] || !upper_same(imm_i, 12);
      end
      FmtU: begin
        instr_o   = {imm_i[31:12], rd_i, opcode_i};
        imm_err_o = |imm_i[11:0];
      end
      FmtJ: begin
        instr_o   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        imm_err_o = imm_i[0] || !upper_same(imm_i, 20);
      end
      default: begin
        instr_o   = 32'h0;
        imm_err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// RV32I instruction encoder: packs request fields at acceptance and queues
// {instr, imm_err} in a 2-entry FIFO; counts consumed outputs.
module imm_encoder
  import riscv_enc_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         fmt,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [2:0]         funct3,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [6:0]         funct7,
  input  logic [31:0]        imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        instr,
  output logic               imm_err,
  output logic [COUNT_W-1:0] enc_count
);

  enc_t               pack_enc;
  enc_t               mem_q [2];
  enc_t               mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic [COUNT_W-1:0] enc_count_q, enc_count_d;
  logic               push, pop;

  imm_pack u_imm_pack (
    .fmt_i     (fmt),
    .opcode_i  (opcode),
    .rd_i      (rd),
    .funct3_i  (funct3),
    .rs1_i     (rs1),
    .rs2_i     (rs2),
    .funct7_i  (funct7),
    .imm_i     (imm),
    .instr_o   (pack_enc.instr),
    .imm_err_o (pack_enc.imm_err)
  );

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    enc_count_d = enc_count_q + COUNT_W'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = pack_enc;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      enc_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enc_count_q <= enc_count_d;
    end
  end

  // Outputs read as zero whenever the FIFO is empty, so no stale word is visible.
  always_comb begin
    instr   = 32'h0;
    imm_err = 1'b0;
    if (out_valid) begin
      instr   = mem_q[rd_ptr_q].instr;
      imm_err = mem_q[rd_ptr_q].imm_err;
    end
  end

  assign enc_count = enc_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: hand-computed encodings, backpressure,
// streaming and mid-operation reset.
module tb_imm_encoder;
  import riscv_enc_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] enc_count;
  int          total;
  int          bad;
  int          exp_cnt;

  imm_encoder_if bus ();

  imm_encoder #(.COUNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .fmt       (bus.fmt),
    .opcode    (bus.opcode),
    .rd        (bus.rd),
    .funct3    (bus.funct3),
    .rs1       (bus.rs1),
    .rs2       (bus.rs2),
    .funct7    (bus.funct7),
    .imm       (bus.imm),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .instr     (bus.instr),
    .imm_err   (bus.imm_err),
    .enc_count (enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] opc, input logic [4:0] d,
                         input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [6:0] f7, input logic [31:0] im);
    bus.fmt    = f;
    bus.opcode = opc;
    bus.rd     = d;
    bus.funct3 = f3;
    bus.rs1    = s1;
    bus.rs2    = s2;
    bus.funct7 = f7;
    bus.imm    = im;
  endtask

  // One request with out_ready=1: output valid one cycle after acceptance, popped next edge.
  task automatic single(input string tag, input logic [31:0] exp_instr, input logic exp_err);
    bus.in_valid = 1'b1;
    check({tag, "_pre_valid"}, 32'(bus.out_valid), 32'd0);
    step();
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_instr"}, bus.instr, exp_instr);
    check({tag, "_err"}, 32'(bus.imm_err), 32'(exp_err));
    step();
    exp_cnt++;
    check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_count"}, 32'(enc_count), 32'(exp_cnt));
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    exp_cnt      = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_req(3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_err", 32'(bus.imm_err), 32'd0);
    check("rst_count", 32'(enc_count), 32'd0);

    set_req(FmtI, OpcOpImm, 5'd5, 3'd0, 5'd1, 5'd0, 7'd0, 32'hFFFF_FFFF);
    single("i_neg1", 32'hFFF0_8293, 1'b0);
    set_req(FmtS, OpcStore, 5'd0, 3'd2, 5'd2, 5'd3, 7'd0, 32'd8);
    single("s_8", 32'h0031_2423, 1'b0);
    set_req(FmtI, OpcOpImm, 5'd5, 3'd0, 5'd1, 5'd0, 7'd0, 32'h0000_0800);
    single("i_range", 32'h8000_8293, 1'b1);
    set_req(FmtB, OpcBranch, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3);
    single("b_odd", 32'h0020_8163, 1'b1);
    set_req(FmtB, OpcBranch, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC);
    single("b_neg4", 32'hFE20_8EE3, 1'b0);
    set_req(FmtU, OpcLui, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    single("u_lui", 32'h1234_52B7, 1'b0);
    set_req(FmtJ, OpcJal, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0800);
    single("j_2048", 32'h0010_00EF, 1'b0);
    set_req(FmtJ, OpcJal, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    single("j_odd", 32'h0000_006F, 1'b1);
    set_req(FmtR, OpcOp, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'hDEAD_BEEF);
    single("r_sub", 32'h4031_00B3, 1'b0);
    set_req(3'd7, OpcOp, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'd0);
    single("fmt7", 32'h0, 1'b1);

    // Backpressure: two accepts fill the FIFO, third request is refused.
    bus.out_ready = 1'b0;
    set_req(FmtI, OpcOpImm, 5'd5, 3'd0, 5'd1, 5'd0, 7'd0, 32'hFFFF_FFFF);
    bus.in_valid = 1'b1;
    step();
    check("bp_ready1", 32'(bus.in_ready), 32'd1);
    set_req(FmtS, OpcStore, 5'd0, 3'd2, 5'd2, 5'd3, 7'd0, 32'd8);
    step();
    check("bp_ready2", 32'(bus.in_ready), 32'd0);
    check("bp_head_a", bus.instr, 32'hFFF0_8293);
    set_req(FmtU, OpcLui, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    step();
    bus.in_valid = 1'b0;
    check("bp_ready3", 32'(bus.in_ready), 32'd0);
    check("bp_head_stable", bus.instr, 32'hFFF0_8293);
    check("bp_count_held", 32'(enc_count), 32'(exp_cnt));
    bus.out_ready = 1'b1;
    step();
    exp_cnt++;
    check("bp_second", bus.instr, 32'h0031_2423);
    check("bp_ready_back", 32'(bus.in_ready), 32'd1);
    step();
    exp_cnt++;
    check("bp_empty", 32'(bus.out_valid), 32'd0);
    check("bp_count", 32'(enc_count), 32'(exp_cnt));

    // Streaming: push and pop each edge keeps occupancy at one.
    set_req(FmtR, OpcOp, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'd0);
    bus.in_valid = 1'b1;
    step();
    check("st_a", bus.instr, 32'h4031_00B3);
    set_req(FmtS, OpcStore, 5'd0, 3'd2, 5'd2, 5'd3, 7'd0, 32'd8);
    step();
    exp_cnt++;
    check("st_b", bus.instr, 32'h0031_2423);
    check("st_ready", 32'(bus.in_ready), 32'd1);
    set_req(FmtJ, OpcJal, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0800);
    step();
    exp_cnt++;
    bus.in_valid = 1'b0;
    check("st_c", bus.instr, 32'h0010_00EF);
    step();
    exp_cnt++;
    check("st_empty", 32'(bus.out_valid), 32'd0);
    check("st_count", 32'(enc_count), 32'(exp_cnt));

    // Reset with FIFO full and a live handshake on both sides.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    step();
    step();
    check("rr_full", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rr_out_valid", 32'(bus.out_valid), 32'd0);
    check("rr_count", 32'(enc_count), 32'd0);
    check("rr_in_ready", 32'(bus.in_ready), 32'd1);
    check("rr_instr", bus.instr, 32'h0);
    step();
    check("rr_no_stale", 32'(bus.out_valid), 32'd0);
    check("rr_count2", 32'(enc_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
